// File: rtl/temp_poller_if.sv
// ----------------------------------------------------------------------------
// temp_poller_if
//   Request/acknowledge bus between the temperature poller (initiator) and
//   the four temperature sensors (responders).
//
//   sns_req   initiator -> sensor  request to the selected sensor
//   sns_sel   initiator -> sensor  sensor index 0..3, stable while sns_req=1
//   sns_ack   sensor -> initiator  response strobe, meaningful only with sns_req
//   sns_data  sensor -> initiator  reading, qualified by sns_ack
// ----------------------------------------------------------------------------
interface temp_poller_if #(
    parameter int unsigned W = 16
);
    logic         sns_req;
    logic [1:0]   sns_sel;
    logic         sns_ack;
    logic [W-1:0] sns_data;

    modport master (
        output sns_req,
        output sns_sel,
        input  sns_ack,
        input  sns_data
    );

    modport slave (
        input  sns_req,
        input  sns_sel,
        output sns_ack,
        output sns_data
    );
endinterface

// File: rtl/temp_poller.sv
// ----------------------------------------------------------------------------
// temp_poller
//   Polls four temperature sensors round-robin over a req/ack bus, collects
//   one reading per sensor into shadow registers and commits all four to
//   temp1..temp4 together with a one-cycle temps_valid pulse. A sensor that
//   does not answer within TIMEOUT wait cycles is flagged in sns_fault and
//   keeps its last good reading, so the downstream comparator never stalls.
//
// Ports
//   clk          in   system clock, rising edge
//   _rst         in   synchronous reset, active-low
//   enable       in   run polling rounds (looked at only in IDLE and GAP)
//   sns          --   sensor bus, master side (req/sel out, ack/data in)
//   temp1..temp4 out  committed readings of sensors 0..3
//   temps_valid  out  one-cycle pulse while a newly committed frame is shown
//   sns_fault    out  bit i = sensor i timed out on its latest poll
// ----------------------------------------------------------------------------
module temp_poller #(
    parameter int unsigned W        = 16,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned POLL_GAP = 1000
) (
    input  logic          clk,
    input  logic          _rst,
    input  logic          enable,
    temp_poller_if.master sns,
    output logic [W-1:0]  temp1,
    output logic [W-1:0]  temp2,
    output logic [W-1:0]  temp3,
    output logic [W-1:0]  temp4,
    output logic          temps_valid,
    output logic [3:0]    sns_fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_COMMIT = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    // Last wait-counter value before the channel is declared dead.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    // Last gap-counter value; unused when POLL_GAP is 0.
    localparam logic [31:0] GAP_LAST  = (POLL_GAP > 0) ? 32'(POLL_GAP - 1) : 32'd0;

    state_t              state_q,  state_d;
    logic [1:0]          sel_q,    sel_d;
    logic [15:0]         wcnt_q,   wcnt_d;
    logic [31:0]         gcnt_q,   gcnt_d;
    logic [3:0][W-1:0]   shadow_q, shadow_d;
    logic [3:0][W-1:0]   temp_q,   temp_d;
    logic [3:0]          fault_q,  fault_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_q  <= S_IDLE;
            sel_q    <= 2'd0;
            wcnt_q   <= 16'd0;
            gcnt_q   <= 32'd0;
            shadow_q <= '0;
            temp_q   <= '0;
            fault_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            wcnt_q   <= wcnt_d;
            gcnt_q   <= gcnt_d;
            shadow_q <= shadow_d;
            temp_q   <= temp_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wcnt_d   = wcnt_q;
        gcnt_d   = gcnt_q;
        shadow_d = shadow_q;
        temp_d   = temp_q;
        fault_d  = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    sel_d   = 2'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wcnt_d  = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack on the timeout cycle still counts as a good read.
                if (sns.sns_ack) begin
                    shadow_d[sel_q] = sns.sns_data;
                    fault_d[sel_q]  = 1'b0;
                    state_d         = S_NEXT;
                end else if (wcnt_q == WAIT_LAST) begin
                    // Shadow keeps the last good reading of a dead sensor.
                    fault_d[sel_q] = 1'b1;
                    state_d        = S_NEXT;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            S_NEXT: begin
                if (sel_q != 2'd3) begin
                    sel_d   = sel_q + 2'd1;
                    state_d = S_REQ;
                end else begin
                    // Load all four outputs at once so the frame is coherent.
                    temp_d  = shadow_q;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                sel_d  = 2'd0;
                gcnt_d = 32'd0;
                if (POLL_GAP > 0)
                    state_d = S_GAP;
                else
                    state_d = enable ? S_REQ : S_IDLE;
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST)
                    state_d = enable ? S_REQ : S_IDLE;
                else
                    gcnt_d = gcnt_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state; req is high through REQ and WAIT
    // only, which guarantees a low cycle (NEXT) between transactions.
    always_comb begin
        sns.sns_req = (state_q == S_REQ) || (state_q == S_WAIT);
        sns.sns_sel = sel_q;
        temps_valid = (state_q == S_COMMIT);
        temp1       = temp_q[0];
        temp2       = temp_q[1];
        temp3       = temp_q[2];
        temp4       = temp_q[3];
        sns_fault   = fault_q;
    end

endmodule

// File: tb/tb_temp_poller.sv
module tb_temp_poller;
    localparam int unsigned W     = 16;
    localparam int          TMO   = 8;
    localparam int          GAP   = 4;
    localparam int          NEVER = 1000;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] temp1, temp2, temp3, temp4;
    logic         temps_valid;
    logic [3:0]   sns_fault;

    temp_poller_if #(.W(W)) bus ();

    temp_poller #(.W(W), .TIMEOUT(TMO), .POLL_GAP(GAP)) dut (
        .clk        (clk),
        ._rst       (rst_n),
        .enable     (enable),
        .sns        (bus),
        .temp1      (temp1),
        .temp2      (temp2),
        .temp3      (temp3),
        .temp4      (temp4),
        .temps_valid(temps_valid),
        .sns_fault  (sns_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Sensor behaviour: k[i] = cycles from req rise to ack (>=1, NEVER = dead).
    // mode 0 = clean, 1 = random spurious acks while req=0, 2 = ack held high.
    int           k [4];
    logic [W-1:0] val [4];
    int           mode     = 0;
    int           rise_cnt = 0;
    int           sel_err  = 0;
    bit           drop_sel1 = 1'b0;

    // Reference model state: what the poller should hold after each round.
    logic [3:0][W-1:0] ref_shadow = '0;
    logic [3:0][W-1:0] ref_temp   = '0;
    logic [3:0]        ref_fault  = '0;

    // Sensor responder and bus monitor.
    initial begin : responder
        bit   prev_req;
        logic [1:0] prev_sel;
        int   cnt;
        prev_req = 1'b0;
        prev_sel = 2'd0;
        cnt      = 0;
        bus.sns_ack  = 1'b0;
        bus.sns_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.sns_req && !prev_req) begin
                cnt = 0;
                rise_cnt++;
            end else if (bus.sns_req) begin
                cnt++;
                if (bus.sns_sel !== prev_sel) sel_err++;
            end
            prev_req = bus.sns_req;
            prev_sel = bus.sns_sel;
            if (mode == 2) begin
                bus.sns_ack  = 1'b1;
                bus.sns_data = bus.sns_req ? val[bus.sns_sel] : W'($urandom);
            end else if (bus.sns_req) begin
                bus.sns_ack  = (cnt == k[bus.sns_sel]);
                bus.sns_data = (cnt == k[bus.sns_sel]) ? val[bus.sns_sel] : W'($urandom);
            end else begin
                bus.sns_ack  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.sns_data = W'($urandom);
            end
        end
    end

    // Applies one round to the reference model; returns the expected index of
    // the commit cycle counting the first REQ cycle as 1.
    task automatic model_round(output int exp_cyc);
        exp_cyc = 1;
        for (int i = 0; i < 4; i++) begin
            if (k[i] <= TMO) begin
                ref_shadow[i] = val[i];
                ref_fault[i]  = 1'b0;
                exp_cyc += k[i] + 2;
            end else begin
                ref_fault[i] = 1'b1;
                exp_cyc += TMO + 2;
            end
        end
        ref_temp = ref_shadow;
    endtask

    // From IDLE: one enable edge leaves IDLE; returns in the first REQ cycle.
    task automatic start_round(input bit keep_enable);
        enable = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_enable) enable = 1'b0;
    endtask

    // Waits (bounded) for temps_valid; idx = cycle index of the commit.
    task automatic finish_round(output int idx, output bit ok);
        idx = 1;
        while (!temps_valid && idx < 400) begin
            if (drop_sel1 && bus.sns_sel == 2'd1) enable = 1'b0;
            @(posedge clk);
            #1;
            idx++;
        end
        ok = temps_valid;
    endtask

    task automatic settle();
        enable = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.sns_req !== 1'b0 || bus.sns_sel !== 2'd0 || temps_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: req=%b sel=%0d valid=%b, required 0/0/0",
                     bus.sns_req, bus.sns_sel, temps_valid);
        end
        tests_run++;
        if ({temp4, temp3, temp2, temp1} !== 64'd0 || sns_fault !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_data: temps=%h fault=%b, required 0/0",
                     {temp4, temp3, temp2, temp1}, sns_fault);
        end
    endtask

    task automatic test_nominal();
        int exp, idx;
        bit ok;
        k   = '{1, 1, 1, 1};
        val = '{16'd100, 16'd101, 16'd99, 16'd98};
        model_round(exp);
        start_round(1'b0);
        finish_round(idx, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL nominal_commit: no temps_valid, required pulse"); end
        tests_run++;
        if (idx !== exp) begin tests_failed++; $display("FAIL nominal_latency: %0d, required %0d", idx, exp); end
        tests_run++;
        if ({temp4, temp3, temp2, temp1} !== ref_temp) begin
            tests_failed++;
            $display("FAIL nominal_temps: %h, required %h", {temp4, temp3, temp2, temp1}, ref_temp);
        end
        tests_run++;
        if (sns_fault !== ref_fault) begin tests_failed++; $display("FAIL nominal_fault: %b, required %b", sns_fault, ref_fault); end
        @(posedge clk);
        #1;
        tests_run++;
        if (temps_valid !== 1'b0) begin tests_failed++; $display("FAIL nominal_pulse_width: valid=%b, required 0", temps_valid); end
        settle();
    endtask

    // Sensor 2 dead for one round, then healthy again.
    task automatic test_timeout();
        int exp, idx;
        bit ok;
        for (int r = 0; r < 2; r++) begin
            k   = (r == 0) ? '{1, 1, NEVER, 1} : '{1, 1, 1, 1};
            val = '{W'($urandom), W'($urandom), (r == 0) ? 16'd555 : 16'd97, W'($urandom)};
            model_round(exp);
            start_round(1'b0);
            finish_round(idx, ok);
            tests_run++;
            if (!ok || idx !== exp) begin
                tests_failed++;
                $display("FAIL timeout_latency r%0d: valid=%b idx=%0d, required 1 at %0d", r, ok, idx, exp);
            end
            tests_run++;
            if ({temp4, temp3, temp2, temp1} !== ref_temp || sns_fault !== ref_fault) begin
                tests_failed++;
                $display("FAIL timeout_frame r%0d: temps=%h fault=%b, required %h/%b",
                         r, {temp4, temp3, temp2, temp1}, sns_fault, ref_temp, ref_fault);
            end
            settle();
        end
    endtask

    // Ack on the last allowed wait cycle (success) and one cycle late (fault).
    task automatic test_exact_timeout();
        int exp, idx;
        bit ok;
        k   = '{TMO, TMO + 1, 2, 3};
        val = '{W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        model_round(exp);
        start_round(1'b0);
        finish_round(idx, ok);
        tests_run++;
        if (!ok || idx !== exp) begin
            tests_failed++;
            $display("FAIL exact_timeout_latency: valid=%b idx=%0d, required 1 at %0d", ok, idx, exp);
        end
        tests_run++;
        if (temp1 !== val[0] || sns_fault !== 4'b0010) begin
            tests_failed++;
            $display("FAIL exact_timeout_capture: temp1=%h fault=%b, required %h/0010", temp1, sns_fault, val[0]);
        end
        tests_run++;
        if ({temp4, temp3, temp2, temp1} !== ref_temp) begin
            tests_failed++;
            $display("FAIL exact_timeout_temps: %h, required %h", {temp4, temp3, temp2, temp1}, ref_temp);
        end
        settle();
    endtask

    // Spurious acks while req=0, then ack held permanently high.
    task automatic test_spurious_ack();
        int exp, idx, r0;
        bit ok;
        for (int r = 0; r < 2; r++) begin
            mode = r + 1;
            for (int i = 0; i < 4; i++) begin
                k[i]   = (mode == 2) ? 1 : $urandom_range(1, 4);
                val[i] = W'($urandom);
            end
            model_round(exp);
            r0 = rise_cnt;
            sel_err = 0;
            start_round(1'b0);
            finish_round(idx, ok);
            tests_run++;
            if (!ok || idx !== exp) begin
                tests_failed++;
                $display("FAIL spurious_latency m%0d: valid=%b idx=%0d, required 1 at %0d", mode, ok, idx, exp);
            end
            tests_run++;
            if ({temp4, temp3, temp2, temp1} !== ref_temp || sns_fault !== ref_fault) begin
                tests_failed++;
                $display("FAIL spurious_frame m%0d: temps=%h fault=%b, required %h/%b",
                         mode, {temp4, temp3, temp2, temp1}, sns_fault, ref_temp, ref_fault);
            end
            tests_run++;
            if (rise_cnt - r0 !== 4 || sel_err !== 0) begin
                tests_failed++;
                $display("FAIL spurious_req_rises m%0d: rises=%0d sel_changes=%0d, required 4/0",
                         mode, rise_cnt - r0, sel_err);
            end
            mode = 0;
            settle();
        end
    endtask

    task automatic test_reset_mid_wait();
        int exp, idx, n;
        bit ok;
        k   = '{1, NEVER, 1, 1};
        val = '{W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        start_round(1'b0);
        n = 0;
        while (!(bus.sns_req && bus.sns_sel == 2'd1) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.sns_req !== 1'b0 || temps_valid !== 1'b0 || bus.sns_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL midreset_ctrl: req=%b valid=%b sel=%0d, required 0/0/0",
                     bus.sns_req, temps_valid, bus.sns_sel);
        end
        tests_run++;
        if ({temp4, temp3, temp2, temp1} !== 64'd0 || sns_fault !== 4'd0) begin
            tests_failed++;
            $display("FAIL midreset_data: temps=%h fault=%b, required 0/0", {temp4, temp3, temp2, temp1}, sns_fault);
        end
        ref_shadow = '0;
        ref_temp   = '0;
        ref_fault  = '0;
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        tests_run++;
        if (bus.sns_req !== 1'b1 || bus.sns_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL midreset_restart: req=%b sel=%0d, required 1/0", bus.sns_req, bus.sns_sel);
        end
        model_round(exp);
        finish_round(idx, ok);
        tests_run++;
        if (!ok || idx !== exp || {temp4, temp3, temp2, temp1} !== ref_temp || sns_fault !== ref_fault) begin
            tests_failed++;
            $display("FAIL midreset_frame: valid=%b idx=%0d temps=%h fault=%b, required 1/%0d/%h/%b",
                     ok, idx, {temp4, temp3, temp2, temp1}, sns_fault, exp, ref_temp, ref_fault);
        end
        settle();
    endtask

    // Continuous polling with a gap, then enable dropped during sel=1.
    task automatic test_back_to_back();
        int exp, idx, g, hi;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            k[i]   = $urandom_range(1, 3);
            val[i] = W'($urandom);
        end
        model_round(exp);
        start_round(1'b1);
        finish_round(idx, ok);
        tests_run++;
        if (!ok || idx !== exp || {temp4, temp3, temp2, temp1} !== ref_temp) begin
            tests_failed++;
            $display("FAIL b2b_frame1: valid=%b idx=%0d temps=%h, required 1/%0d/%h",
                     ok, idx, {temp4, temp3, temp2, temp1}, exp, ref_temp);
        end
        g = 0;
        while (!bus.sns_req && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        tests_run++;
        if (g !== GAP + 1) begin tests_failed++; $display("FAIL b2b_gap: next req %0d cycles after commit, required %0d", g, GAP + 1); end
        for (int i = 0; i < 4; i++) val[i] = W'($urandom);
        model_round(exp);
        drop_sel1 = 1'b1;
        finish_round(idx, ok);
        drop_sel1 = 1'b0;
        tests_run++;
        if (!ok || idx !== exp || {temp4, temp3, temp2, temp1} !== ref_temp || sns_fault !== ref_fault) begin
            tests_failed++;
            $display("FAIL b2b_frame2: valid=%b idx=%0d temps=%h fault=%b, required 1/%0d/%h/%b",
                     ok, idx, {temp4, temp3, temp2, temp1}, sns_fault, exp, ref_temp, ref_fault);
        end
        hi = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.sns_req) hi++;
        end
        tests_run++;
        if (hi !== 0) begin tests_failed++; $display("FAIL b2b_stop: req high %0d cycles after disable, required 0", hi); end
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        tests_run++;
        if (bus.sns_req !== 1'b1 || bus.sns_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL b2b_idle_restart: req=%b sel=%0d, required 1/0", bus.sns_req, bus.sns_sel);
        end
        model_round(exp);
        finish_round(idx, ok);
        tests_run++;
        if (!ok || idx !== exp || {temp4, temp3, temp2, temp1} !== ref_temp) begin
            tests_failed++;
            $display("FAIL b2b_frame3: valid=%b idx=%0d temps=%h, required 1/%0d/%h",
                     ok, idx, {temp4, temp3, temp2, temp1}, exp, ref_temp);
        end
        settle();
    endtask

    task automatic test_random();
        int exp, idx;
        bit ok;
        for (int r = 0; r < 6; r++) begin
            mode = $urandom_range(0, 1);
            for (int i = 0; i < 4; i++) begin
                k[i]   = $urandom_range(1, TMO + 2);
                val[i] = W'($urandom);
            end
            model_round(exp);
            start_round(1'b0);
            finish_round(idx, ok);
            tests_run++;
            if (!ok || idx !== exp) begin
                tests_failed++;
                $display("FAIL random_latency r%0d: valid=%b idx=%0d, required 1 at %0d", r, ok, idx, exp);
            end
            tests_run++;
            if ({temp4, temp3, temp2, temp1} !== ref_temp || sns_fault !== ref_fault) begin
                tests_failed++;
                $display("FAIL random_frame r%0d: temps=%h fault=%b, required %h/%b",
                         r, {temp4, temp3, temp2, temp1}, sns_fault, ref_temp, ref_fault);
            end
            mode = 0;
            settle();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        k      = '{1, 1, 1, 1};
        val    = '{16'd0, 16'd0, 16'd0, 16'd0};
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_nominal();
        test_timeout();
        test_exact_timeout();
        test_spurious_ack();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
